// File: rtl/bus_master.sv
// bus_master: single-outstanding CPU-to-bus-switch master (write / read with optional wait states)
//
// Ports:
//   clk               system clock; all state changes on the rising edge
//   reset             asynchronous, active-low reset
//   req, we           CPU request and direction (1=write), sampled only while ready=1
//   addr, wdata       CPU address (24b) and write data (16b), sampled with req
//   ready             idle and able to accept a request
//   rdata             last successfully read word
//   done, err         one-cycle completion / no-slave-matched pulses
//   bus_address       address driven to every bus switch; holds the last latched address
//   bus_data          shared data bus; driven only while bus_load_enable=1
//   bus_load_enable   write strobe to the bus switches
//   bus_output_enable read enable to the bus switches
//   bus_match         OR of all bus switch match outputs
module bus_master #(
    parameter int RD_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic [15:0] rdata,
    output logic        done,
    output logic        err,
    output logic [23:0] bus_address,
    inout  wire  [15:0] bus_data,
    output logic        bus_load_enable,
    output logic        bus_output_enable,
    input  logic        bus_match
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT, S_RD_CAP, S_TURN} state_t;

    localparam bit         HAS_WAIT  = RD_WAIT > 0;
    localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

    state_t      state, state_nx;
    logic [15:0] wdata_q;
    logic [3:0]  cnt;
    logic        ready_nx, done_nx, err_nx, load_nx, oe_nx;

    // The master only ever drives the bus during the single write cycle.
    assign bus_data = bus_load_enable ? wdata_q : 16'bz;

    // State, counter and registered outputs; the *_nx values are the next-cycle outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            ready             <= 1'b1;
            done              <= 1'b0;
            err               <= 1'b0;
            bus_load_enable   <= 1'b0;
            bus_output_enable <= 1'b0;
            bus_address       <= 24'd0;
            wdata_q           <= 16'd0;
            rdata             <= 16'd0;
            cnt               <= 4'd0;
        end else begin
            state             <= state_nx;
            ready             <= ready_nx;
            done              <= done_nx;
            err               <= err_nx;
            bus_load_enable   <= load_nx;
            bus_output_enable <= oe_nx;
            cnt               <= (state == S_RD_WAIT) ? cnt + 4'd1 : 4'd0;
            if (state == S_IDLE && req) begin
                bus_address <= addr;
                wdata_q     <= wdata;
            end
            if (state == S_RD_CAP)
                rdata <= bus_data;
        end
    end

    // The state itself latches the direction, so `we` is only needed at acceptance.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (req) state_nx = we ? S_WR : S_RD;
            S_WR:      state_nx = S_IDLE;
            S_RD:      state_nx = !bus_match ? S_TURN : HAS_WAIT ? S_RD_WAIT : S_RD_CAP;
            S_RD_WAIT: if (cnt == WAIT_LAST) state_nx = S_RD_CAP;
            S_RD_CAP:  state_nx = S_TURN;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they line up with it once registered.
    always_comb begin
        ready_nx = state_nx == S_IDLE;
        load_nx  = state_nx == S_WR;
        oe_nx    = state_nx inside {S_RD, S_RD_WAIT, S_RD_CAP};
        done_nx  = (state == S_WR && bus_match) || state == S_RD_CAP;
        err_nx   = (state == S_WR || state == S_RD) && !bus_match;
    end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: scoreboard bench for bus_master with RD_WAIT=0 and RD_WAIT=3 instances
module tb_bus_master;
    typedef struct {
        logic        err;
        logic [15:0] rd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;

    logic        req0 = 0, we0 = 0, req3 = 0, we3 = 0;
    logic [23:0] addr0 = 0, addr3 = 0;
    logic [15:0] wdata0 = 0, wdata3 = 0;
    logic        ready0, done0, err0, ble0, boe0, m0;
    logic        ready3, done3, err3, ble3, boe3, m3;
    logic [15:0] rdata0, rdata3;
    logic [23:0] ba0, ba3;
    wire  [15:0] bd0, bd3;

    // Switch model: matches addresses with bit 23 clear, returns data one edge after output_enable.
    logic        drv0 = 0, drv3 = 0;
    logic [15:0] sw0 = 0, sw3 = 0;
    assign m0  = (ble0 | boe0) & ~ba0[23];
    assign m3  = (ble3 | boe3) & ~ba3[23];
    assign bd0 = drv0 ? sw0 : 16'bz;
    assign bd3 = drv3 ? sw3 : 16'bz;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        drv0 <= boe0 & m0;
        drv3 <= boe3 & m3;
    end

    bus_master #(.RD_WAIT(0)) dut (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .rdata(rdata0), .done(done0), .err(err0), .bus_address(ba0),
        .bus_data(bd0), .bus_load_enable(ble0), .bus_output_enable(boe0), .bus_match(m0)
    );

    bus_master #(.RD_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .ready(ready3), .rdata(rdata3), .done(done3), .err(err3), .bus_address(ba3),
        .bus_data(bd3), .bus_load_enable(ble3), .bus_output_enable(boe3), .bus_match(m3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request on instance d (0 or 3) at a falling edge; returns at the falling edge after acceptance.
    task automatic go(input int d, input logic w, input logic [23:0] a, input logic [15:0] wd,
                      input logic e, input logic [15:0] rd, input int lat, input bit push);
        int n = 0;
        while (!(d == 0 ? ready0 : ready3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", n < 50, 1);
        if (d == 0) begin
            req0 = 1; we0 = w; addr0 = a; wdata0 = wd;
            if (push) q0.push_back('{e, rd, cyc + 1 + lat});
        end else begin
            req3 = 1; we3 = w; addr3 = a; wdata3 = wd;
            if (push) q3.push_back('{e, rd, cyc + 1 + lat});
        end
        @(negedge clk);
        req0 = 0;
        req3 = 0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("excl0", ble0 & boe0, 0);
            if (done0 | err0) begin
                chk("both0", done0 & err0, 0);
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected0: done=%b err=%b with nothing outstanding", done0, err0);
                end else begin
                    e0 = q0.pop_front();
                    chk("err0", err0, e0.err);
                    chk("rdata0", rdata0, e0.rd);
                    chk("lat0", cyc, e0.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("excl3", ble3 & boe3, 0);
            if (done3 | err3) begin
                chk("both3", done3 & err3, 0);
                n_checks++;
                if (q3.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected3: done=%b err=%b with nothing outstanding", done3, err3);
                end else begin
                    e3 = q3.pop_front();
                    chk("err3", err3, e3.err);
                    chk("rdata3", rdata3, e3.rd);
                    chk("lat3", cyc, e3.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int oe;
        #2 reset = 0;
        #1;
        chk("rst_ready", ready0, 1);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_en", {ble0, boe0}, 0);
        chk("rst_addr", ba0, 0);
        chk("rst_rdata", rdata0, 0);
        chk("rst_ready3", ready3, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1;

        // write 0xBEEF -> 0x001234
        go(0, 1, 24'h001234, 16'hBEEF, 0, 16'h0000, 1, 1);
        chk("wr_le", ble0, 1);
        chk("wr_oe", boe0, 0);
        chk("wr_addr", ba0, 24'h001234);
        chk("wr_data", bd0, 16'hBEEF);
        chk("wr_ready", ready0, 0);
        @(negedge clk);
        chk("wr_ready_back", ready0, 1);
        chk("wr_le_off", ble0, 0);
        chk("wr_addr_hold", ba0, 24'h001234);

        // read 0x001010 -> 0xA5A5
        sw0 = 16'hA5A5;
        go(0, 0, 24'h001010, 16'h0000, 0, 16'hA5A5, 2, 1);
        chk("rd_oe", boe0, 1);
        chk("rd_le", ble0, 0);
        chk("rd_addr", ba0, 24'h001010);
        @(negedge clk);
        chk("rd_cap_oe", boe0, 1);
        chk("rd_cap_bus", bd0, 16'hA5A5);
        @(negedge clk);
        chk("rd_turn_ready", ready0, 0);
        chk("rd_turn_oe", boe0, 0);
        @(negedge clk);
        chk("rd_ready_back", ready0, 1);
        chk("rd_addr_hold", ba0, 24'h001010);

        // read with no slave match
        go(0, 0, 24'h800000, 16'h0000, 1, 16'hA5A5, 1, 1);
        chk("nm_oe", boe0, 1);
        @(negedge clk);
        chk("nm_turn_ready", ready0, 0);
        chk("nm_rdata", rdata0, 16'hA5A5);
        @(negedge clk);
        chk("nm_ready_back", ready0, 1);

        // read then write then write with req held high throughout
        sw0 = 16'h5A5A;
        c0 = cyc;
        req0 = 1; we0 = 0; addr0 = 24'h000200;
        q0.push_back('{1'b0, 16'h5A5A, c0 + 3});
        @(negedge clk);
        we0 = 1; addr0 = 24'h000300; wdata0 = 16'hC0DE;
        q0.push_back('{1'b0, 16'h5A5A, c0 + 6});
        @(negedge clk);
        @(negedge clk);
        chk("b2b_turn_en", {ble0, boe0}, 0);
        chk("b2b_turn_ready", ready0, 0);
        @(negedge clk);
        chk("b2b_idle_ready", ready0, 1);
        @(negedge clk);
        chk("b2b_wr_le", ble0, 1);
        chk("b2b_wr_data", bd0, 16'hC0DE);
        addr0 = 24'h000400; wdata0 = 16'h1111;
        q0.push_back('{1'b0, 16'h5A5A, c0 + 8});
        @(negedge clk);
        chk("waw_idle_ready", ready0, 1);
        @(negedge clk);
        chk("waw_wr_data", bd0, 16'h1111);
        chk("waw_wr_addr", ba0, 24'h000400);
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("waw_rdata", rdata0, 16'h5A5A);

        // RD_WAIT=3 read -> 0x1357, output_enable high for five cycles
        sw3 = 16'h1357;
        go(3, 0, 24'h000010, 16'h0000, 0, 16'h1357, 5, 1);
        oe = 0;
        for (int i = 0; i < 7; i++) begin
            oe += int'(boe3);
            @(negedge clk);
        end
        chk("w3_oe_cycles", oe, 5);

        // asynchronous reset in the middle of RD_WAIT
        go(3, 0, 24'h000030, 16'h0000, 0, 16'h0000, 5, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wait", boe3, 1);
        #2 reset = 0;
        #1;
        chk("arst_ready3", ready3, 1);
        chk("arst_en3", {ble3, boe3}, 0);
        chk("arst_de3", {done3, err3}, 0);
        chk("arst_addr3", ba3, 0);
        chk("arst_rdata3", rdata3, 0);
        chk("arst_rdata0", rdata0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        @(negedge clk);

        // first requests after reset release
        go(3, 1, 24'h000020, 16'h7777, 0, 16'h0000, 1, 1);
        chk("post_wr_data3", bd3, 16'h7777);
        sw0 = 16'h2468;
        go(0, 0, 24'h000040, 16'h0000, 0, 16'h2468, 2, 1);
        repeat (6) @(negedge clk);
        chk("q0_empty", q0.size(), 0);
        chk("q3_empty", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
